branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch comparator in the pipelined core.
- Resolves branches in EX with the same 5-bit BrOp encoding.
- Adds a PC-indexed branch history table (BHT) of 2-bit saturating counters. The BHT gives IF a taken/not-taken prediction.
- Detects mispredictions, issues a registered flush plus redirect PC, and keeps branch/mispredict performance counters.

Parameters:
- XLEN, 32, operand and PC width
- BHT_ENTRIES, 16, number of BHT counters; power of two, >= 2
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  core clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- if_pc_i  in  XLEN  PC of the instruction being fetched
- if_pred_taken_o  out  1  prediction for if_pc_i (combinational BHT read)
- ex_valid_i  in  1  EX holds a valid instruction
- ex_stall_i  in  1  EX stalled; when 1, no resolution, no update, no flush
- ex_brop_i  in  5  branch opcode
- ex_rs1_i  in  XLEN  first operand
- ex_rs2_i  in  XLEN  second operand
- ex_pc_i  in  XLEN  PC of the EX instruction
- ex_target_i  in  XLEN  computed branch/jump target
- ex_pred_taken_i  in  1  prediction carried down the pipe from IF
- flush_o  out  1  registered: squash IF/ID, redirect fetch
- redirect_pc_o  out  XLEN  registered redirect address, valid when flush_o=1
- br_count_o  out  CNT_W  resolved conditional branches
- mispred_count_o  out  CNT_W  mispredicted instructions (conditional and jump)

Behaviour:
- Opcode decode:
  - BrOp[4]=1: unconditional jump, taken.
  - BrOp[4:3]=00: not a branch, taken=0.
  - BrOp[4:3]=01, conditional, decoded by BrOp[2:0]:
    - 000: eq
    - 001: ne
    - 100: signed lt
    - 101: signed ge
    - 110: unsigned lt
    - 111: unsigned ge
    - 010, 011: taken=0, but still counted as a conditional branch.
  - Signed compares treat operands as two's complement XLEN.
- Resolution:
  - Active only when `resolve = ex_valid_i && !ex_stall_i`.
  - `mispredict = resolve && (taken != ex_pred_taken_i) && (BrOp[4] || BrOp[4:3]==01)`.
  - Non-branch instructions never mispredict, even if ex_pred_taken_i=1.
- Flush and redirect, latency 1 (registered on the clk edge after resolve):
  - flush_o = mispredict.
  - redirect_pc_o = target when taken, otherwise ex_pc_i + 4 (mod 2^XLEN).
  - flush_o is high for exactly one cycle per mispredict.
  - redirect_pc_o holds its last value when flush_o=0.
- BHT:
  - BHT_ENTRIES counters, index = PC[log2(BHT_ENTRIES)+1:2].
  - if_pred_taken_o = counter[MSB] of the entry indexed by if_pc_i.
  - On resolve of a conditional branch only, at the clk edge: increment if taken, else decrement, saturating at 0 and 3.
  - Jumps and non-branches never update the BHT.
- Read/write same index in the same cycle: IF sees the pre-update value; no bypass.
- Counters:
  - br_count_o increments on every resolved conditional branch.
  - mispred_count_o increments on every mispredict.
  - Both wrap from 2^CNT_W-1 to 0.
- Reset (asynchronous, any time, including mid-stall):
  - All BHT entries = 2'b01 (weakly not taken).
  - flush_o=0, redirect_pc_o=0, both counters=0.
  - Hence if_pred_taken_o=0 during reset.
  - The first edge after release behaves normally.
- ex_stall_i=1 with ex_valid_i=1: state is frozen. The same instruction resolves exactly once, on the first non-stalled cycle.

Decomposition:
- Package branch_pkg:
  - BrOp localparams (BR_NONE, BR_JUMP, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU).
  - bht_ctr_t (2-bit) and BHT_RESET = 2'b01.
  - Helper function sat_update(ctr, taken).
- One combinational sub-module, branch_cmp (XLEN, rs1, rs2, brop -> taken, is_cond, is_jump), reused by EX forwarding logic.
- BHT array, flush register and counters stay in the top module.

Test Plan:
- Reset, then if_pc_i=0x40 -> if_pred_taken_o=0. Conditional BEQ (brop 01000) at pc 0x40, rs1=rs2=5, pred=0 resolves -> next cycle flush_o=1, redirect_pc_o=target 0x80, br_count=1, mispred=1. Then if_pc_i=0x40 -> pred=1.
- BLT signed, rs1=0xFFFFFFFF, rs2=1, pred=1 -> taken, no flush. Same operands with BLTU, pred=1 -> not taken, flush_o=1, redirect_pc_o=ex_pc+4.
- Four taken branches at pc 0x100 then one not-taken -> counter saturates at 3 and drops to 2, prediction stays 1. Two more not-taken -> prediction becomes 0.
- JAL (brop 10000), pred=0 -> flush, redirect=target, BHT entry unchanged, br_count unchanged, mispred_count +1. Non-branch (00000) with pred=1 -> no flush.
- ex_stall_i=1 for 3 cycles holding a mispredicting BNE -> no flush during the stall, one flush after release, counters +1 only. Assert rst_n low mid-stall -> all outputs and counters 0 immediately.
- Preload mispred_count_o to 0xFFFF via 65535 mispredicts (or a CNT_W=4 build) -> the next mispredict wraps it to 0. Same-index IF read during an EX update returns the old prediction.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch-unit definitions: BrOp encodings, BHT counter type and its
// saturating update rule.
package branch_pkg;

    localparam logic [4:0] BR_NONE = 5'b00000;
    localparam logic [4:0] BR_JUMP = 5'b10000;
    localparam logic [4:0] BR_EQ   = 5'b01000;
    localparam logic [4:0] BR_NE   = 5'b01001;
    localparam logic [4:0] BR_LT   = 5'b01100;
    localparam logic [4:0] BR_GE   = 5'b01101;
    localparam logic [4:0] BR_LTU  = 5'b01110;
    localparam logic [4:0] BR_GEU  = 5'b01111;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_RESET = 2'b01;

    // Two-bit saturating counter step: up on taken, down on not-taken.
    function automatic bht_ctr_t sat_update(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11)
            nxt = ctr + 2'd1;
        else if (!taken && ctr != 2'b00)
            nxt = ctr - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// EX-stage branch resolution bus: instruction, operands and carried prediction.
interface branch_predict_unit_if #(
    parameter int XLEN = 32
);
    logic            ex_valid_i;
    logic            ex_stall_i;
    logic [4:0]      ex_brop_i;
    logic [XLEN-1:0] ex_rs1_i;
    logic [XLEN-1:0] ex_rs2_i;
    logic [XLEN-1:0] ex_pc_i;
    logic [XLEN-1:0] ex_target_i;
    logic            ex_pred_taken_i;

    modport master (
        output ex_valid_i, ex_stall_i, ex_brop_i, ex_rs1_i, ex_rs2_i,
               ex_pc_i, ex_target_i, ex_pred_taken_i
    );

    modport slave (
        input ex_valid_i, ex_stall_i, ex_brop_i, ex_rs1_i, ex_rs2_i,
              ex_pc_i, ex_target_i, ex_pred_taken_i
    );
endinterface

// File: rtl/branch_predict_unit_cmp.sv
// Combinational BrOp decoder/comparator; also reused by EX forwarding logic.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      brop,
    output logic            taken,
    output logic            is_cond,
    output logic            is_jump
);
    logic cond_res;

    assign is_jump = brop[4];
    assign is_cond = (brop[4:3] == 2'b01);

    always_comb begin
        cond_res = 1'b0;
        case (brop[2:0])
            BR_EQ[2:0]:  cond_res = (rs1 == rs2);
            BR_NE[2:0]:  cond_res = (rs1 != rs2);
            BR_LT[2:0]:  cond_res = ($signed(rs1) <  $signed(rs2));
            BR_GE[2:0]:  cond_res = ($signed(rs1) >= $signed(rs2));
            BR_LTU[2:0]: cond_res = (rs1 <  rs2);
            BR_GEU[2:0]: cond_res = (rs1 >= rs2);
            default:     cond_res = 1'b0;  // 010/011: counted, never taken
        endcase
    end

    assign taken = is_jump | (is_cond & cond_res);
endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution with a PC-indexed 2-bit BHT, registered flush/redirect
// and branch/mispredict performance counters.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc_i,
    output logic             if_pred_taken_o,
    branch_predict_unit_if.slave ex,
    output logic             flush_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [CNT_W-1:0] br_count_o,
    output logic [CNT_W-1:0] mispred_count_o
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    bht_ctr_t         bht [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             taken;
    logic             is_cond;
    logic             is_jump;
    logic             resolve;
    logic             mispredict;
    logic             unused_if_pc;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .rs1     (ex.ex_rs1_i),
        .rs2     (ex.ex_rs2_i),
        .brop    (ex.ex_brop_i),
        .taken   (taken),
        .is_cond (is_cond),
        .is_jump (is_jump)
    );

    assign if_idx = if_pc_i[IDX_W+1:2];
    assign ex_idx = ex.ex_pc_i[IDX_W+1:2];
    assign unused_if_pc = ^{if_pc_i[XLEN-1:IDX_W+2], if_pc_i[1:0]};

    // Read is from the registered array, so a same-cycle update is not visible.
    assign if_pred_taken_o = bht[if_idx][1];

    assign resolve    = ex.ex_valid_i && !ex.ex_stall_i;
    assign mispredict = resolve && (taken != ex.ex_pred_taken_i) && (is_jump || is_cond);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= BHT_RESET;
        end else if (resolve && is_cond) begin
            bht[ex_idx] <= sat_update(bht[ex_idx], taken);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_o       <= 1'b0;
            redirect_pc_o <= '0;
        end else begin
            flush_o <= mispredict;
            if (mispredict)
                redirect_pc_o <= taken ? ex.ex_target_i : ex.ex_pc_i + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_o      <= '0;
            mispred_count_o <= '0;
        end else begin
            if (resolve && is_cond)
                br_count_o <= br_count_o + CNT_W'(1);
            if (mispredict)
                mispred_count_o <= mispred_count_o + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed table-driven bench for branch_predict_unit (CNT_W=4 build so the
// counter wrap is reachable in a few cycles).
module tb_branch_predict_unit;
    import branch_pkg::*;

    typedef struct {
        logic [4:0]  brop;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pred;
        logic        flush;
        logic [31:0] redir;
        logic [3:0]  br;
        logic [3:0]  mis;
        logic        pb;
        logic        pa;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc_i;
    logic        if_pred_taken_o;
    logic        flush_o;
    logic [31:0] redirect_pc_o;
    logic [3:0]  br_count_o;
    logic [3:0]  mispred_count_o;

    int nvec = 0;
    int nerr = 0;

    branch_predict_unit_if #(.XLEN(32)) bus ();

    branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(16), .CNT_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_pc_i         (if_pc_i),
        .if_pred_taken_o (if_pred_taken_o),
        .ex              (bus),
        .flush_o         (flush_o),
        .redirect_pc_o   (redirect_pc_o),
        .br_count_o      (br_count_o),
        .mispred_count_o (mispred_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic stall);
        bus.ex_valid_i      = 1'b1;
        bus.ex_stall_i      = stall;
        bus.ex_brop_i       = v.brop;
        bus.ex_rs1_i        = v.rs1;
        bus.ex_rs2_i        = v.rs2;
        bus.ex_pc_i         = v.pc;
        bus.ex_target_i     = v.tgt;
        bus.ex_pred_taken_i = v.pred;
        if_pc_i             = v.pc;
    endtask

    task automatic check_state(input string tag, input logic fl, input logic [31:0] rd,
                               input logic [3:0] br, input logic [3:0] mis);
        chk({tag, " flush"},    {31'b0, flush_o}, {31'b0, fl});
        chk({tag, " redirect"}, redirect_pc_o, rd);
        chk({tag, " br_count"}, {28'b0, br_count_o}, {28'b0, br});
        chk({tag, " mis_count"}, {28'b0, mispred_count_o}, {28'b0, mis});
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(v, 1'b0);
        #1 chk({tag, " pred_before"}, {31'b0, if_pred_taken_o}, {31'b0, v.pb});
        @(posedge clk);
        #1;
        check_state(tag, v.flush, v.redir, v.br, v.mis);
        chk({tag, " pred_after"}, {31'b0, if_pred_taken_o}, {31'b0, v.pa});
    endtask

    vec_t tv [15];
    vec_t v;

    initial begin
        //         brop     rs1           rs2           pc        tgt       pred fl  redir     br  mis pb  pa
        tv[0]  = '{BR_EQ,   32'd5,        32'd5,        32'h40,   32'h80,   0,   1,  32'h80,   1,  1,  0,  1};
        tv[1]  = '{BR_LT,   32'hFFFFFFFF, 32'd1,        32'h208,  32'h300,  1,   0,  32'h80,   2,  1,  0,  1};
        tv[2]  = '{BR_LTU,  32'hFFFFFFFF, 32'd1,        32'h208,  32'h300,  1,   1,  32'h20C,  3,  2,  1,  0};
        tv[3]  = '{BR_EQ,   32'd0,        32'd0,        32'h100,  32'h180,  1,   0,  32'h20C,  4,  2,  1,  1};
        tv[4]  = '{BR_EQ,   32'd0,        32'd0,        32'h100,  32'h180,  1,   0,  32'h20C,  5,  2,  1,  1};
        tv[5]  = '{BR_EQ,   32'd0,        32'd0,        32'h100,  32'h180,  1,   0,  32'h20C,  6,  2,  1,  1};
        tv[6]  = '{BR_EQ,   32'd0,        32'd0,        32'h100,  32'h180,  1,   0,  32'h20C,  7,  2,  1,  1};
        tv[7]  = '{BR_NE,   32'd0,        32'd0,        32'h100,  32'h180,  1,   1,  32'h104,  8,  3,  1,  1};
        tv[8]  = '{BR_NE,   32'd0,        32'd0,        32'h100,  32'h180,  1,   1,  32'h104,  9,  4,  1,  0};
        tv[9]  = '{BR_NE,   32'd0,        32'd0,        32'h100,  32'h180,  0,   0,  32'h104,  10, 4,  0,  0};
        tv[10] = '{BR_JUMP, 32'd0,        32'd0,        32'h208,  32'h400,  0,   1,  32'h400,  10, 5,  0,  0};
        tv[11] = '{BR_NONE, 32'd0,        32'd0,        32'h208,  32'h500,  1,   0,  32'h400,  10, 5,  0,  0};
        tv[12] = '{5'b01010, 32'd3,       32'd3,        32'h208,  32'h600,  1,   1,  32'h20C,  11, 6,  0,  0};
        tv[13] = '{BR_GE,   32'd1,        32'hFFFFFFFF, 32'h40,   32'h80,   0,   1,  32'h80,   12, 7,  0,  0};
        tv[14] = '{BR_GEU,  32'd1,        32'hFFFFFFFF, 32'h40,   32'h80,   0,   0,  32'h80,   13, 7,  0,  0};

        rst_n = 1'b0;
        if_pc_i = 32'h40;
        bus.ex_valid_i = 1'b0;
        bus.ex_stall_i = 1'b0;
        bus.ex_brop_i = BR_NONE;
        bus.ex_rs1_i = '0;
        bus.ex_rs2_i = '0;
        bus.ex_pc_i = '0;
        bus.ex_target_i = '0;
        bus.ex_pred_taken_i = 1'b0;
        #2;
        check_state("reset", 1'b0, 32'h0, 4'd0, 4'd0);
        chk("reset pred", {31'b0, if_pred_taken_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++)
            apply(tv[i], $sformatf("vec%0d", i));

        // Stalled mispredicting BNE: frozen for 3 cycles, resolves once.
        v = '{BR_NE, 32'd1, 32'd2, 32'h208, 32'h500, 0, 1, 32'h500, 14, 8, 0, 1};
        @(negedge clk);
        drive(v, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check_state($sformatf("stall%0d", i), 1'b0, 32'h80, 4'd13, 4'd7);
        end
        @(negedge clk);
        bus.ex_stall_i = 1'b0;
        @(posedge clk);
        #1 check_state("stall_release", 1'b1, 32'h500, 4'd14, 4'd8);
        @(negedge clk);
        bus.ex_valid_i = 1'b0;
        @(posedge clk);
        #1 check_state("stall_after", 1'b0, 32'h500, 4'd14, 4'd8);

        // Mispredict counter wraps 15 -> 0 at the CNT_W=4 boundary.
        for (int i = 0; i < 8; i++) begin
            v = '{BR_JUMP, 32'd0, 32'd0, 32'h300, 32'h800, 0, 1, 32'h800, 14,
                  4'((9 + i) % 16), 0, 0};
            apply(v, $sformatf("wrap%0d", i));
        end

        // Branch counter wraps too; also trains entry 1 up to strongly taken.
        v = '{BR_EQ, 32'd7, 32'd7, 32'h104, 32'h180, 1, 0, 32'h800, 15, 0, 0, 1};
        apply(v, "train0");
        v = '{BR_EQ, 32'd7, 32'd7, 32'h104, 32'h180, 1, 0, 32'h800, 0, 0, 1, 1};
        apply(v, "train1");
        v = '{BR_JUMP, 32'd0, 32'd0, 32'h104, 32'h700, 0, 1, 32'h700, 0, 1, 1, 1};
        apply(v, "jal_pre_rst");

        // Reset asserted mid-stall while flush_o is high.
        v = '{BR_NE, 32'd1, 32'd2, 32'h104, 32'h900, 0, 1, 32'h900, 1, 1, 0, 1};
        @(negedge clk);
        drive(v, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_state("mid_rst", 1'b0, 32'h0, 4'd0, 4'd0);
        chk("mid_rst pred", {31'b0, if_pred_taken_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check_state("post_rst_stall", 1'b0, 32'h0, 4'd0, 4'd0);
        @(negedge clk);
        bus.ex_stall_i = 1'b0;
        @(posedge clk);
        #1;
        check_state("post_rst", 1'b1, 32'h900, 4'd1, 4'd1);
        chk("post_rst pred", {31'b0, if_pred_taken_o}, 32'h1);
        @(negedge clk);
        bus.ex_valid_i = 1'b0;
        @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
